// File: rtl/alu_operand_entry_if.sv
// alu_operand_entry_if: board-side keys/switches in, issued ALU operand word and live entry status out
interface alu_operand_entry_if;
  logic [3:0] digit_sw;
  logic [1:0] op_sw;
  logic       digit_key;
  logic       sign_key;
  logic       enter_key;
  logic [7:0] operand;
  logic       sign;
  logic [1:0] operator;
  logic       step;
  logic [7:0] entry_value;
  logic       entry_sign;
  logic [1:0] digit_count;
  logic       ovf_flag;
  modport master (
    output digit_sw, op_sw, digit_key, sign_key, enter_key,
    input  operand, sign, operator, step, entry_value, entry_sign, digit_count, ovf_flag
  );
  modport slave (
    input  digit_sw, op_sw, digit_key, sign_key, enter_key,
    output operand, sign, operator, step, entry_value, entry_sign, digit_count, ovf_flag
  );
endinterface

// File: rtl/alu_operand_entry.sv
// alu_operand_entry: debounced decimal keypad entry (clk, reset, bus: keys/switches in, operand/sign/operator/step/entry status out)
module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  alu_operand_entry_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, CLEAR} state_t;
  state_t         state_q;
  logic [2:0]     raw, sync1_q, sync2_q, deb_q, deb_d, evt_q;
  logic [CW-1:0]  cnt_q [3];
  logic [CW-1:0]  cnt_d [3];
  logic [7:0]     operand_q, value_q;
  logic           sign_q, step_q, esign_q, ovf_q;
  logic [1:0]     operator_q, count_q;
  logic [11:0]    acc, nxt;
  logic           digit_ok;
  assign raw = {bus.enter_key, bus.sign_key, bus.digit_key};
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] != CW'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + 1'b1 : '0;
      deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? sync2_q[i] : deb_q[i];
    end
  end
  assign acc      = {4'd0, value_q};
  assign nxt      = (acc << 3) + (acc << 1) + {8'd0, bus.digit_sw};
  assign digit_ok = bus.digit_sw <= 4'd9 && count_q != 2'd3;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      evt_q      <= '0;
      cnt_q      <= '{default: '0};
      state_q    <= IDLE;
      operand_q  <= '0;
      sign_q     <= 1'b1;
      operator_q <= '0;
      step_q     <= 1'b0;
      value_q    <= '0;
      esign_q    <= 1'b1;
      count_q    <= '0;
      ovf_q      <= 1'b1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      evt_q   <= deb_d & ~deb_q;
      cnt_q   <= cnt_d;
      case (state_q)
        IDLE: begin
          if (evt_q[2]) begin
            state_q    <= ISSUE;
            step_q     <= 1'b1;
            operand_q  <= value_q;
            sign_q     <= esign_q;
            operator_q <= bus.op_sw;
          end else if (evt_q[0]) begin
            if (digit_ok) begin
              value_q <= nxt > 12'd255 ? 8'd255 : nxt[7:0];
              ovf_q   <= nxt > 12'd255 ? 1'b0 : ovf_q;
              count_q <= count_q + 2'd1;
            end
          end else if (evt_q[1]) begin
            esign_q <= ~esign_q;
          end
        end
        ISSUE: begin
          state_q <= CLEAR;
          step_q  <= 1'b0;
          value_q <= '0;
          esign_q <= 1'b1;
          count_q <= '0;
          ovf_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          step_q  <= 1'b0;
          value_q <= '0;
          esign_q <= 1'b1;
          count_q <= '0;
          ovf_q   <= 1'b1;
        end
      endcase
    end
  end
  assign bus.operand     = operand_q;
  assign bus.sign        = sign_q;
  assign bus.operator    = operator_q;
  assign bus.step        = step_q;
  assign bus.entry_value = value_q;
  assign bus.entry_sign  = esign_q;
  assign bus.digit_count = count_q;
  assign bus.ovf_flag    = ovf_q;
endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry: random key sequences against a decimal-entry model with an issue scoreboard
module tb_alu_operand_entry;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  alu_operand_entry_if bus();
  alu_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];
  int mv, mc;
  bit ms, movf;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void model_clear();
    mv = 0;
    mc = 0;
    ms = 1'b1;
    movf = 1'b0;
  endfunction
  task automatic set_key(input int k, input logic v);
    if (k == 0) bus.digit_key = v;
    else if (k == 1) bus.sign_key = v;
    else bus.enter_key = v;
  endtask
  task automatic press(input int k, input int hold);
    @(negedge clk);
    set_key(k, 1'b1);
    repeat (hold) @(negedge clk);
    set_key(k, 1'b0);
    repeat (D + 6) @(negedge clk);
  endtask
  task automatic check_entry(input string tag);
    chk({tag, "_entry_value"}, int'(bus.entry_value), mv);
    chk({tag, "_entry_sign"}, int'(bus.entry_sign), int'(ms));
    chk({tag, "_digit_count"}, int'(bus.digit_count), mc);
    chk({tag, "_ovf_flag"}, int'(bus.ovf_flag), movf ? 0 : 1);
  endtask
  task automatic model_digit(input int d);
    if (d <= 9 && mc < 3) begin
      mv = mv * 10 + d;
      if (mv > 255) begin
        mv = 255;
        movf = 1'b1;
      end
      mc++;
    end
  endtask
  task automatic digit(input int d);
    bus.digit_sw = d[3:0];
    press(0, D + 2);
    model_digit(d);
    check_entry("digit");
  endtask
  task automatic sgn();
    press(1, D + 2);
    ms = !ms;
    check_entry("sign");
  endtask
  task automatic enter(input int op);
    bus.op_sw = op[1:0];
    exp_q.push_back({mv[7:0], ms, op[1:0]});
    press(2, D + 2);
    model_clear();
    check_entry("enter");
  endtask
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (bus.step === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_step: got step=1 required no step");
        end else begin
          e = exp_q.pop_front();
          chk("issue_operand_sign_operator", int'({bus.operand, bus.sign, bus.operator}), int'(e));
        end
        @(negedge clk);
        chk("post_issue_clear", int'({bus.step, bus.entry_value, bus.entry_sign, bus.digit_count, bus.ovf_flag}),
            int'({1'b0, 8'd0, 1'b1, 2'd0, 1'b1}));
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "timeout");
  end
  initial begin
    bus.digit_sw = '0;
    bus.op_sw = '0;
    bus.digit_key = 1'b0;
    bus.sign_key = 1'b0;
    bus.enter_key = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({bus.operand, bus.sign, bus.operator, bus.step, bus.entry_value, bus.entry_sign, bus.digit_count, bus.ovf_flag}),
        int'({8'd0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, 2'd0, 1'b1}));
    reset = 1'b0;
    digit(1); digit(2); digit(7); enter(2);
    digit(2); digit(5); digit(6); enter(0);
    digit(1); digit(2); digit(3); digit(4); digit(12); enter(1);
    sgn(); digit(9); enter(3); sgn(); sgn();
    bus.digit_sw = 4'd5;
    @(negedge clk);
    bus.digit_key = 1'b1;
    repeat (D + 2) @(negedge clk);
    chk("latency_before_event", int'(bus.entry_value), mv);
    @(negedge clk);
    model_digit(5);
    chk("latency_after_event", int'(bus.entry_value), mv);
    bus.digit_key = 1'b0;
    repeat (D + 6) @(negedge clk);
    bus.digit_sw = 4'd3;
    press(0, D - 1);
    check_entry("short_pulse");
    digit(3);
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) digit($urandom_range(0, 15));
      else if (r < 8) sgn();
      else enter($urandom_range(0, 3));
    end
    enter($urandom_range(0, 3));
    digit(4); digit(2);
    bus.op_sw = 2'd1;
    @(negedge clk);
    bus.enter_key = 1'b1;
    repeat (D + 2) @(negedge clk);
    chk("pre_reset_entry_value", int'(bus.entry_value), 42);
    reset = 1'b1;
    bus.enter_key = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    chk("mid_entry_reset_outputs", int'({bus.operand, bus.sign, bus.operator, bus.step, bus.entry_value, bus.entry_sign, bus.digit_count, bus.ovf_flag}),
        int'({8'd0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, 2'd0, 1'b1}));
    repeat (D + 8) @(negedge clk);
    chk("pending_issues", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
